// File: rtl/double_to_float_pkg.sv
// rtl/double_to_float_pkg.sv - shared fpu constants: state encoding, biases, exponent limits, canonical NaNs
package double_to_float_pkg;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_UNPACK,
        ST_SPECIAL_CASES,
        ST_NORMALISE,
        ST_ROUND,
        ST_PACK,
        ST_PUT_Z
    } state_t;

    localparam logic signed [12:0] DOUBLE_BIAS     = 13'sd1023;
    localparam logic signed [12:0] FLOAT_BIAS      = 13'sd127;
    localparam logic signed [12:0] FLOAT_EXP_MIN   = -13'sd126;
    localparam logic signed [12:0] FLOAT_EXP_MAX   = 13'sd127;
    // Below this exponent even the smallest denormal would round to zero.
    localparam logic signed [12:0] FLOAT_FLUSH_EXP = -13'sd151;

    localparam logic [31:0] FLOAT_QNAN  = 32'hffc00000;
    localparam logic [63:0] DOUBLE_QNAN = 64'hfff8000000000000;

endpackage

// File: rtl/double_to_float.sv
// rtl/double_to_float.sv - binary64 to binary32 narrowing, round-to-nearest-even, stb/ack on both sides
// Optional macro DOUBLE_TO_FLOAT_NAN_PAYLOAD_EN: NaN results keep sign and top payload bits instead of QNAN.
module double_to_float
    import double_to_float_pkg::*;
#(
    parameter logic [31:0] QNAN = FLOAT_QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t             state, state_next;
    logic               input_a_ack_next, output_z_stb_next;
    logic [31:0]        output_z_next;
    logic [63:0]        a, a_next;
    logic signed [12:0] e, e_next;
    logic [23:0]        z_m, z_m_next;
    logic               guard, guard_next;
    logic               round_bit, round_bit_next;
    logic               sticky, sticky_next;
    logic [31:0]        z, z_next;
    logic [31:0]        nan_result;

`ifdef DOUBLE_TO_FLOAT_NAN_PAYLOAD_EN
    assign nan_result = {a[63], 8'hff, 1'b1, a[50:29]};
`else
    assign nan_result = QNAN;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= state_next;
            input_a_ack  <= input_a_ack_next;
            output_z_stb <= output_z_stb_next;
        end
    end

    always_ff @(posedge clk) begin
        output_z  <= output_z_next;
        a         <= a_next;
        e         <= e_next;
        z_m       <= z_m_next;
        guard     <= guard_next;
        round_bit <= round_bit_next;
        sticky    <= sticky_next;
        z         <= z_next;
    end

    always_comb begin
        state_next        = state;
        input_a_ack_next  = input_a_ack;
        output_z_stb_next = output_z_stb;
        output_z_next     = output_z;
        a_next            = a;
        e_next            = e;
        z_m_next          = z_m;
        guard_next        = guard;
        round_bit_next    = round_bit;
        sticky_next       = sticky;
        z_next            = z;

        case (state)
            ST_GET_A: begin
                input_a_ack_next = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    a_next           = input_a;
                    input_a_ack_next = 1'b0;
                    state_next       = ST_UNPACK;
                end
            end

            ST_UNPACK: begin
                e_next     = $signed({2'b00, a[62:52]}) - DOUBLE_BIAS;
                state_next = ST_SPECIAL_CASES;
            end

            ST_SPECIAL_CASES: begin
                state_next = ST_PUT_Z;
                if (a[62:52] == 11'h7ff && a[51:0] != 52'd0) begin
                    z_next = nan_result;
                end else if (a[62:52] == 11'h7ff) begin
                    z_next = {a[63], 8'hff, 23'd0};
                end else if (a[62:52] == 11'h000) begin
                    // Every double denormal is far below the float range.
                    z_next = {a[63], 31'd0};
                end else if (e < FLOAT_FLUSH_EXP) begin
                    z_next = {a[63], 31'd0};
                end else if (e > FLOAT_EXP_MAX) begin
                    z_next = {a[63], 8'hff, 23'd0};
                end else begin
                    z_m_next       = {1'b1, a[51:29]};
                    guard_next     = a[28];
                    round_bit_next = a[27];
                    sticky_next    = |a[26:0];
                    state_next     = ST_NORMALISE;
                end
            end

            ST_NORMALISE: begin
                // One denormalising shift per cycle; guard/round/sticky ride along.
                if (e < FLOAT_EXP_MIN) begin
                    z_m_next       = z_m >> 1;
                    guard_next     = z_m[0];
                    round_bit_next = guard;
                    sticky_next    = sticky | round_bit;
                    e_next         = e + 13'sd1;
                end else begin
                    state_next = ST_ROUND;
                end
            end

            ST_ROUND: begin
                state_next = ST_PACK;
                if (guard && (round_bit || sticky || z_m[0])) begin
                    if (z_m == 24'hffffff) begin
                        z_m_next = 24'h800000;
                        e_next   = e + 13'sd1;
                    end else begin
                        z_m_next = z_m + 24'd1;
                    end
                end
            end

            ST_PACK: begin
                state_next = ST_PUT_Z;
                if (e > FLOAT_EXP_MAX) begin
                    z_next = {a[63], 8'hff, 23'd0};
                end else begin
                    z_next = {a[63], 8'(e + FLOAT_BIAS), z_m[22:0]};
                    if (e == FLOAT_EXP_MIN && !z_m[23]) begin
                        z_next[30:23] = 8'd0;
                    end
                end
            end

            ST_PUT_Z: begin
                output_z_stb_next = 1'b1;
                output_z_next     = z;
                if (output_z_stb && output_z_ack) begin
                    output_z_stb_next = 1'b0;
                    state_next        = ST_GET_A;
                end
            end

            default: begin
                state_next = ST_GET_A;
            end
        endcase
    end

endmodule

// File: tb/tb_double_to_float.sv
// tb/tb_double_to_float.sv - self-checking bench for double_to_float against an arithmetic rounding model
module tb_double_to_float;

    logic        clk;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int total = 0;
    int bad   = 0;

    double_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef DOUBLE_TO_FLOAT_NAN_PAYLOAD_EN
    localparam bit NAN_PAYLOAD = 1'b1;
`else
    localparam bit NAN_PAYLOAD = 1'b0;
`endif

    // Value-level model: scale the 53-bit significand to the float quantum and round half-even.
    function automatic logic [31:0] model_z(input logic [63:0] a);
        int                ef;
        int                exp_u;
        int                shift;
        logic              s;
        longint unsigned   m, q, rem, half, bits;
        s  = a[63];
        ef = int'(a[62:52]);
        if (ef == 2047) begin
            if (a[51:0] != 52'd0)
                return NAN_PAYLOAD ? {s, 8'hff, 1'b1, a[50:29]} : 32'hffc00000;
            return {s, 8'hff, 23'd0};
        end
        if (ef == 0) return {s, 31'd0};
        exp_u = ef - 1023;
        if (exp_u > 127) return {s, 8'hff, 23'd0};
        if (exp_u < -151) return {s, 31'd0};
        m     = {11'd0, 1'b1, a[51:0]};
        shift = 29 + ((exp_u < -126) ? (-126 - exp_u) : 0);
        q     = m >> shift;
        rem   = m & ((64'd1 << shift) - 64'd1);
        half  = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (exp_u < -126) bits = q;
        else bits = (longint'(exp_u + 127) << 23) + q - (64'd1 << 23);
        if (bits >= 64'h7f800000) return {s, 8'hff, 23'd0};
        return {s, bits[30:0]};
    endfunction

    function automatic int model_lat(input logic [63:0] a);
        int ef;
        int exp_u;
        ef = int'(a[62:52]);
        exp_u = ef - 1023;
        if (ef == 2047 || ef == 0 || exp_u > 127 || exp_u < -151) return 3;
        return 6 + ((exp_u < -126) ? (-126 - exp_u) : 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, then wait until output_z_stb is seen; lat counts edges from the accept edge.
    task automatic send(input logic [63:0] a, output logic [31:0] z, output int lat, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (!input_a_ack && n < 50) begin
            step();
            n++;
        end
        if (!input_a_ack) begin
            to  = 1'b1;
            lat = 0;
            z   = 32'd0;
            return;
        end
        input_a     = a;
        input_a_stb = 1'b1;
        step();
        input_a_stb = 1'b0;
        n = 0;
        while (!output_z_stb && n < 60) begin
            step();
            n++;
        end
        to  = !output_z_stb;
        lat = n;
        z   = output_z;
    endtask

    task automatic consume();
        output_z_ack = 1'b1;
        step();
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (input_a_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack: got %b expected 0", input_a_ack);
        end
        total++;
        if (output_z_stb !== 1'b0) begin
            bad++;
            $display("FAIL reset_stb: got %b expected 0", output_z_stb);
        end
        rst = 1'b0;
        step();
        total++;
        if (input_a_ack !== 1'b1) begin
            bad++;
            $display("FAIL reset_ack_rise: got %b expected 1", input_a_ack);
        end
    endtask

    task automatic test_ack_stall();
        logic [31:0] z;
        int          lat;
        bit          to;
        send(64'h3FF0000000000000, z, lat, to);
        total++;
        if (to || z !== 32'h3F800000 || lat != 6) begin
            bad++;
            $display("FAIL stall_one: got %h lat %0d to %b expected 3f800000 lat 6", z, lat, to);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (output_z_stb !== 1'b1 || output_z !== 32'h3F800000) begin
                bad++;
                $display("FAIL stall_hold%0d: got stb %b z %h expected stb 1 z 3f800000", i, output_z_stb, output_z);
            end
        end
        consume();
        total++;
        if (output_z_stb !== 1'b0) begin
            bad++;
            $display("FAIL stall_drop: got stb %b expected 0", output_z_stb);
        end
        step();
        total++;
        if (input_a_ack !== 1'b1) begin
            bad++;
            $display("FAIL stall_reack: got %b expected 1", input_a_ack);
        end
    endtask

    task automatic test_rounding();
        logic [63:0] va [0:2];
        logic [31:0] ve [0:2];
        logic [31:0] z;
        int          lat;
        bit          to;
        va = '{64'h400921FB54442D18, 64'h47EFFFFFF0000000, 64'hC7F0000000000000};
        ve = '{32'h40490FDB, 32'h7F800000, 32'hFF800000};
        for (int i = 0; i < 3; i++) begin
            send(va[i], z, lat, to);
            consume();
            total++;
            if (to || z !== ve[i] || lat != (i == 2 ? 3 : 6)) begin
                bad++;
                $display("FAIL rounding[%0d]: got %h lat %0d to %b expected %h", i, z, lat, to, ve[i]);
            end
        end
    endtask

    task automatic test_denormals();
        logic [63:0] va [0:2];
        logic [31:0] ve [0:2];
        int          vl [0:2];
        logic [31:0] z;
        int          lat;
        bit          to;
        va = '{64'h36A0000000000000, 64'h3690000000000000, 64'h01A56E1FC2F8F359};
        ve = '{32'h00000001, 32'h00000000, 32'h00000000};
        vl = '{29, 30, 3};
        for (int i = 0; i < 3; i++) begin
            send(va[i], z, lat, to);
            consume();
            total++;
            if (to || z !== ve[i] || lat != vl[i]) begin
                bad++;
                $display("FAIL denormal[%0d]: got %h lat %0d to %b expected %h lat %0d", i, z, lat, to, ve[i], vl[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [63:0] va [0:2];
        logic [31:0] ve [0:2];
        logic [31:0] z;
        int          lat;
        bit          to;
        va = '{64'h7FF0000000000001, 64'hFFF0000000000000, 64'h8000000000000000};
        ve = '{NAN_PAYLOAD ? 32'h7FC00000 : 32'hFFC00000, 32'hFF800000, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            send(va[i], z, lat, to);
            consume();
            total++;
            if (to || z !== ve[i] || lat != 3) begin
                bad++;
                $display("FAIL special[%0d]: got %h lat %0d to %b expected %h lat 3", i, z, lat, to, ve[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] z;
        int          lat;
        int          n;
        bit          to;
        bit          stale;
        n = 0;
        while (!input_a_ack && n < 50) begin
            step();
            n++;
        end
        input_a     = 64'h36A0000000000000;
        input_a_stb = 1'b1;
        step();
        input_a_stb = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: got stb %b ack %b expected 0 0", output_z_stb, input_a_ack);
        end
        step();
        total++;
        if (input_a_ack !== 1'b1) begin
            bad++;
            $display("FAIL midrst_reack: got %b expected 1", input_a_ack);
        end
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (output_z_stb) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL midrst_stale: got stb 1 after reset expected 0");
        end
        send(64'h3FF0000000000000, z, lat, to);
        consume();
        total++;
        if (to || z !== 32'h3F800000 || lat != 6) begin
            bad++;
            $display("FAIL midrst_next: got %h lat %0d to %b expected 3f800000 lat 6", z, lat, to);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] r;
        logic [31:0] z;
        int          lat;
        int          ef;
        bit          to;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: ef = $urandom_range(0, 2047);
                1: ef = $urandom_range(863, 903);
                2: ef = $urandom_range(1100, 1160);
                default: ef = $urandom_range(896, 1150);
            endcase
            r = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r[51:29] = '1;
            a = {r[63], 11'(ef), r[51:0]};
            send(a, z, lat, to);
            consume();
            total++;
            if (to || z !== model_z(a) || lat != model_lat(a)) begin
                bad++;
                $display("FAIL random[%0d] a=%h: got %h lat %0d to %b expected %h lat %0d",
                         i, a, z, lat, to, model_z(a), model_lat(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        real         num [0:4];
        real         den [0:4];
        logic [63:0] a;
        logic [31:0] z;
        logic [31:0] exp_z;
        int          lat;
        bit          to;
        num = '{1.0, 2.0, 1.0e-40, 22.0, 1.0e39};
        den = '{3.0, 7.0, 3.0, 7.0, 0.1};
        output_z_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a     = $realtobits(num[i] / den[i]);
            exp_z = (i == 0) ? 32'h3EAAAAAB : model_z(a);
            send(a, z, lat, to);
            step();
            total++;
            if (to || z !== exp_z || lat != model_lat(a)) begin
                bad++;
                $display("FAIL b2b[%0d] a=%h: got %h lat %0d to %b expected %h lat %0d",
                         i, a, z, lat, to, exp_z, model_lat(a));
            end
        end
        output_z_ack = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        input_a      = 64'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        test_reset();
        test_ack_stall();
        test_rounding();
        test_denormals();
        test_specials();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
